// File: rtl/hex_pkg.sv
// Shared constants for the hex accumulator: seven-segment glyph table,
// blank pattern, operation/flag types and the digit-count rule.
package hex_pkg;

  // Active-low glyphs, bit order gfedcba, bit 0 = segment a.
  localparam logic [6:0] SEG7 [0:15] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
    7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
    7'b000_0000, 7'b001_1000, 7'b000_1000, 7'b000_0011,
    7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic carry;
    logic overflow;
  } alu_flags_t;

  function automatic int ndig_of(input int width);
    return width / 4;
  endfunction

endpackage

// File: rtl/hex_seg7.sv
// One hex digit: 4-bit nibble to active-low seven-segment pattern.
module hex_seg7
  import hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    seg = SEG7[nibble];
  end

endmodule

// File: rtl/hex_accumulator.sv
// Pushbutton-driven add/subtract accumulator with hex readout of the result,
// the accumulator and the operand. WIDTH must be a multiple of 4, at least 4.
module hex_accumulator
  import hex_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 8,
  localparam int NDIG  = ndig_of(WIDTH)
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               key_n,
  input  logic               clr,
  input  logic               sub,
  input  logic [WIDTH-1:0]   operand,
  output logic [7*NDIG-1:0]  hex_s,
  output logic [7*NDIG-1:0]  hex_a,
  output logic [7*NDIG-1:0]  hex_b,
  output logic               carry,
  output logic               ovf_sticky,
  output logic [CNT_W-1:0]   press_cnt
);

  logic             k1_q, k1_d;
  logic             k2_q, k2_d;
  logic             k3_q, k3_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             press;
  op_e              op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] s;
  alu_flags_t       flags;

  // key_n is asynchronous: two flops for metastability, a third for edge history.
  always_comb begin
    k1_d = key_n;
    k2_d = k1_q;
    k3_d = k2_q;
  end

  assign press = k3_q & ~k2_q;
  assign op    = op_e'(sub);

  // The extra top bit of the zero-extended result is carry-out for add and
  // borrow (A < B unsigned) for subtract.
  always_comb begin
    if (op == OP_SUB) begin
      sum_ext = {1'b0, acc_q} - {1'b0, operand};
    end else begin
      sum_ext = {1'b0, acc_q} + {1'b0, operand};
    end
    s           = sum_ext[WIDTH-1:0];
    flags.carry = sum_ext[WIDTH];
    if (op == OP_SUB) begin
      flags.overflow = (acc_q[WIDTH-1] != operand[WIDTH-1]) &&
                       (s[WIDTH-1] != acc_q[WIDTH-1]);
    end else begin
      flags.overflow = (acc_q[WIDTH-1] == operand[WIDTH-1]) &&
                       (s[WIDTH-1] != acc_q[WIDTH-1]);
    end
  end

  // clr wins over a coincident press; that press is dropped, not held over.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (press) begin
      acc_d = s;
      ovf_d = ovf_q | flags.overflow;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      k1_q  <= 1'b1;
      k2_q  <= 1'b1;
      k3_q  <= 1'b1;
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      k1_q  <= k1_d;
      k2_q  <= k2_d;
      k3_q  <= k3_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign carry      = flags.carry;
  assign ovf_sticky = ovf_q;
  assign press_cnt  = cnt_q;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    hex_seg7 u_seg_s (.nibble(s[4*g +: 4]),       .seg(hex_s[7*g +: 7]));
    hex_seg7 u_seg_a (.nibble(acc_q[4*g +: 4]),   .seg(hex_a[7*g +: 7]));
    hex_seg7 u_seg_b (.nibble(operand[4*g +: 4]), .seg(hex_b[7*g +: 7]));
  end

endmodule

// File: tb/tb_hex_accumulator.sv
// Bench for hex_accumulator: an 8-bit instance checked against vector tables,
// hand sequences and an arithmetic model; a 16-bit/CNT_W=2 instance for width and saturation.
module tb_hex_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        key8_n, clr8, sub8;
  logic [7:0]  op8;
  logic [13:0] hex_s8, hex_a8, hex_b8;
  logic        carry8, ovf8;
  logic [7:0]  cnt8;

  logic        key16_n, clr16, sub16;
  logic [15:0] op16;
  logic [27:0] hex_s16, hex_a16, hex_b16;
  logic        carry16, ovf16;
  logic [1:0]  cnt16;

  hex_accumulator #(.WIDTH(8), .CNT_W(8)) dut8 (
    .Clock(clk), .Resetn(resetn), .key_n(key8_n), .clr(clr8), .sub(sub8),
    .operand(op8), .hex_s(hex_s8), .hex_a(hex_a8), .hex_b(hex_b8),
    .carry(carry8), .ovf_sticky(ovf8), .press_cnt(cnt8)
  );

  hex_accumulator #(.WIDTH(16), .CNT_W(2)) dut16 (
    .Clock(clk), .Resetn(resetn), .key_n(key16_n), .clr(clr16), .sub(sub16),
    .operand(op16), .hex_s(hex_s16), .hex_a(hex_a16), .hex_b(hex_b16),
    .carry(carry16), .ovf_sticky(ovf16), .press_cnt(cnt16)
  );

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
    7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
    7'b000_0000, 7'b001_1000, 7'b000_1000, 7'b000_0011,
    7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110
  };

  function automatic logic [13:0] seg8(input logic [7:0] v);
    return {SEG_TAB[v[7:4]], SEG_TAB[v[3:0]]};
  endfunction

  function automatic logic [27:0] seg16(input logic [15:0] v);
    return {SEG_TAB[v[15:12]], SEG_TAB[v[11:8]], SEG_TAB[v[7:4]], SEG_TAB[v[3:0]]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of the 8-bit instance, in plain integer arithmetic.
  int m_a;
  int m_cnt;
  bit m_ovf;

  function automatic int ref_s(input int a, input int b, input bit sb);
    return sb ? ((a - b) & 255) : ((a + b) & 255);
  endfunction

  function automatic bit ref_carry(input int a, input int b, input bit sb);
    return sb ? (a < b) : ((a + b) > 255);
  endfunction

  function automatic bit ref_ovf(input int a, input int b, input bit sb);
    int sa, sbv, r;
    sa  = (a > 127) ? a - 256 : a;
    sbv = (b > 127) ? b - 256 : b;
    r   = sb ? sa - sbv : sa + sbv;
    return (r > 127) || (r < -128);
  endfunction

  task automatic model_clear();
    m_a = 0; m_cnt = 0; m_ovf = 1'b0;
  endtask

  task automatic model_commit(input int b, input bit sb);
    m_ovf = m_ovf | ref_ovf(m_a, b, sb);
    m_a   = ref_s(m_a, b, sb);
    if (m_cnt < 255) m_cnt++;
  endtask

  // Falling edge before edge n, commit at edge n+2, then release and settle.
  task automatic press(input bit wide);
    @(negedge clk);
    if (wide) key16_n = 1'b0; else key8_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (wide) key16_n = 1'b1; else key8_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_model8(input string tag);
    chk({tag, "_hex_a"}, hex_a8, seg8(8'(m_a)));
    chk({tag, "_cnt"}, cnt8, m_cnt);
    chk({tag, "_ovf"}, ovf8, m_ovf);
  endtask

  typedef struct {
    bit         do_clr;
    bit         sb;
    logic [7:0] b;
    logic [7:0] exp_s;
    bit         exp_c;
    logic [7:0] exp_a;
    bit         exp_ovf;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vecs[0] = '{0, 0, 8'h3C, 8'h3C, 0, 8'h3C, 0, 1};
    vecs[1] = '{0, 0, 8'h3C, 8'h78, 0, 8'h78, 0, 2};
    vecs[2] = '{0, 0, 8'h3C, 8'hB4, 0, 8'hB4, 1, 3};
    vecs[3] = '{1, 0, 8'h05, 8'h05, 0, 8'h05, 0, 1};
    vecs[4] = '{0, 1, 8'h07, 8'hFE, 1, 8'hFE, 0, 2};
    vecs[5] = '{0, 0, 8'h02, 8'h00, 1, 8'h00, 0, 3};
    vecs[6] = '{0, 1, 8'h80, 8'h80, 1, 8'h80, 1, 4};
    vecs[7] = '{0, 1, 8'h01, 8'h7F, 0, 8'h7F, 1, 5};

    resetn = 1'b0;
    key8_n = 1'b1; clr8 = 1'b0; sub8 = 1'b0; op8 = '0;
    key16_n = 1'b1; clr16 = 1'b0; sub16 = 1'b0; op16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_clear();

    chk("reset_hex_a", hex_a8, {7'b100_0000, 7'b100_0000});
    chk("reset_hex_s", hex_s8, {7'b100_0000, 7'b100_0000});
    chk("reset_cnt", cnt8, 0);
    chk("reset_ovf", ovf8, 0);
    chk("reset_hex_a16", hex_a16, seg16(16'h0000));

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_clr) begin
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        model_clear();
      end
      sub8 = vecs[i].sb;
      op8  = vecs[i].b;
      #1;
      chk($sformatf("vec%0d_hex_s", i), hex_s8, seg8(vecs[i].exp_s));
      chk($sformatf("vec%0d_carry", i), carry8, vecs[i].exp_c);
      chk($sformatf("vec%0d_hex_b", i), hex_b8, seg8(vecs[i].b));
      press(1'b0);
      model_commit(vecs[i].b, vecs[i].sb);
      chk($sformatf("vec%0d_hex_a", i), hex_a8, seg8(vecs[i].exp_a));
      chk($sformatf("vec%0d_ovf", i), ovf8, vecs[i].exp_ovf);
      chk($sformatf("vec%0d_cnt", i), cnt8, vecs[i].exp_cnt);
    end

    // Latency and hold: commit exactly at the third rising edge, only once.
    sub8 = 1'b0;
    op8  = 8'h01;
    @(negedge clk);
    key8_n = 1'b0;
    @(posedge clk); #1;
    chk("lat_edge0", hex_a8, seg8(8'(m_a)));
    @(posedge clk); #1;
    chk("lat_edge1", hex_a8, seg8(8'(m_a)));
    @(posedge clk); #1;
    model_commit(8'h01, 1'b0);
    chk("lat_edge2", hex_a8, seg8(8'(m_a)));
    repeat (20) @(negedge clk);
    check_model8("hold");
    key8_n = 1'b1;
    repeat (5) @(negedge clk);
    check_model8("release");

    // clr in the press-pulse cycle: press dropped, not deferred.
    key8_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clr8 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
    model_clear();
    check_model8("clr_press");
    repeat (5) @(negedge clk);
    check_model8("clr_no_defer");
    key8_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset in the press-pulse cycle: no commit.
    op8 = 8'h11;
    press(1'b0);
    model_commit(8'h11, 1'b0);
    check_model8("pre_reset");
    key8_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    key8_n = 1'b1;
    model_clear();
    check_model8("mid_reset");
    repeat (4) @(negedge clk);
    check_model8("post_reset");

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        model_clear();
      end
      sub8 = 1'($urandom_range(0, 1));
      op8  = 8'($urandom_range(0, 255));
      #1;
      chk($sformatf("rnd%0d_hex_s", i), hex_s8, seg8(8'(ref_s(m_a, op8, sub8))));
      chk($sformatf("rnd%0d_carry", i), carry8, ref_carry(m_a, op8, sub8));
      press(1'b0);
      model_commit(op8, sub8);
      check_model8($sformatf("rnd%0d", i));
    end

    // 16-bit instance: wrap with carry, then counter saturation at 3.
    sub16 = 1'b0;
    op16  = 16'h0001;
    press(1'b1);
    chk("w16_a1", hex_a16, seg16(16'h0001));
    op16 = 16'hFFFF;
    #1;
    chk("w16_s_wrap", hex_s16, seg16(16'h0000));
    chk("w16_carry", carry16, 1);
    press(1'b1);
    chk("w16_a_wrap", hex_a16, seg16(16'h0000));
    chk("w16_cnt2", cnt16, 2);
    repeat (3) press(1'b1);
    chk("w16_a_final", hex_a16, seg16(16'hFFFD));
    chk("w16_cnt_sat", cnt16, 3);
    chk("w16_ovf", ovf16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
